data_mem_arbiter: RTL

//  Shares the single-port 128x32 data memory between two requesters: port A (datapath load/store)
//  and port B (loader/debug). Registers the winning request, drives the memory's address/data/RW

---
 rtl/data_mem_arb_pkg.sv | 17 +
 rtl/data_mem_arbiter_arb2_select.sv | 23 ++
 rtl/data_mem_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
// Provides the FSM state enum, default widths and port ids.
package data_mem_arb_pkg;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 32;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_arbiter_arb2_select.sv
// Two-way grant for the data memory arbiter (combinational).
// Ports: a_req, b_req, last_owner in; grant_b out.
// RR_ARB_EN selects round-robin, else fixed A priority.
module arb2_select
  import data_mem_arb_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_owner,
  output logic grant_b
);

`ifdef RR_ARB_EN
  // On a tie, B wins only if A was served last.
  assign grant_b = b_req &
    (~a_req | (last_owner == PORT_A));
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
  assign grant_b = b_req & ~a_req;
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between port A and B.
// Ports: clk, rst_n, a_*/b_* request ports, mem_* pins,
// busy, owner_b. Macro RR_ARB_EN enables round-robin.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic              owner_b
);

  state_t state, state_d;

  logic              grant_b;
  logic              last_owner, last_owner_d;
  logic              owner_b_d;
  logic              mem_rw_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              a_ack_d, b_ack_d;
  logic [DATA_W-1:0] a_rdata_d, b_rdata_d;

  arb2_select u_sel (
    .a_req      (a_req),
    .b_req      (b_req),
    .last_owner (last_owner),
    .grant_b    (grant_b)
  );

  assign busy = (state != IDLE);

  always_comb begin
    state_d      = state;
    last_owner_d = last_owner;
    owner_b_d    = owner_b;
    mem_rw_d     = mem_rw;
    addr_d       = mem_address;
    wdata_d      = mem_data_in;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    a_rdata_d    = a_rdata;
    b_rdata_d    = b_rdata;
    unique case (state)
      IDLE: begin
        mem_rw_d = 1'b0;
        if (a_req | b_req) begin
          owner_b_d    = grant_b;
          last_owner_d = grant_b;
          addr_d       = grant_b ? b_addr : a_addr;
          wdata_d      = grant_b ? b_wdata : a_wdata;
          mem_rw_d     = grant_b ? b_we : a_we;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (!mem_rw) begin
          if (owner_b) b_rdata_d = mem_data_out;
          else         a_rdata_d = mem_data_out;
        end
        mem_rw_d = 1'b0;
        a_ack_d  = ~owner_b;
        b_ack_d  = owner_b;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        mem_rw_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_owner  <= PORT_B;
      owner_b     <= 1'b0;
      mem_rw      <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
    end else begin
      state       <= state_d;
      last_owner  <= last_owner_d;
      owner_b     <= owner_b_d;
      mem_rw      <= mem_rw_d;
      mem_address <= addr_d;
      mem_data_in <= wdata_d;
      a_ack       <= a_ack_d;
      b_ack       <= b_ack_d;
      a_rdata     <= a_rdata_d;
      b_rdata     <= b_rdata_d;
    end
  end

endmodule
